// File: rtl/present80_enc_core.sv
// present80_enc_core -- iterative PRESENT-80 block encryption, one round per clock.
//
// Each RUN cycle does one full round in a single step:
//   1. add the round key key_q[79:16]
//   2. apply the 16-nibble S-box layer
//   3. apply the bit permutation (present80_pbox)
// The key schedule advances on the same edge. After the last round the core
// sits in DONE and shows state ^ final round key until the consumer accepts it.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       plaintext+key offer; accepted when both are high
//   plaintext[63:0]         block to encrypt
//   key[79:0]               cipher key
//   out_valid/out_ready     ciphertext handshake
//   ciphertext[63:0]        result, forced to 0 outside DONE
//   busy                    high in RUN or DONE

// PRESENT bit permutation: input bit i moves to output bit (16*i) mod 63.
// Bit 63 maps to itself.
module present80_pbox (
    input  logic [63:0] din,
    output logic [63:0] dout
);
    for (genvar i = 0; i < 63; i++) begin : g_perm
        assign dout[(i * 16) % 63] = din[i];
    end
    assign dout[63] = din[63];
endmodule

module present80_enc_core #(
    parameter int unsigned NUM_ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] plaintext,
    input  logic [79:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ciphertext,
    output logic        busy
);
    localparam logic [4:0] LAST_RC = 5'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  rc_q, rc_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // ---------------- round datapath ----------------
    logic [63:0] add_key;
    logic [63:0] sbox_out;
    logic [63:0] perm_out;
    logic [79:0] key_rot;
    logic [79:0] key_next;

    assign add_key = state_q ^ key_q[79:16];

    always_comb begin
        sbox_out = '0;
        for (int n = 0; n < 16; n++) begin
            sbox_out[4*n +: 4] = sbox(add_key[4*n +: 4]);
        end
    end

    present80_pbox u_pbox (
        .din  (sbox_out),
        .dout (perm_out)
    );

    // Rotate left by 61, S-box the top nibble, fold the round counter into
    // bits 19:15.
    assign key_rot  = {key_q[18:0], key_q[79:19]};
    assign key_next = {sbox(key_rot[79:76]), key_rot[75:20],
                       key_rot[19:15] ^ rc_q, key_rot[14:0]};

    // ---------------- control ----------------
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = plaintext;
                    key_d   = key;
                    rc_d    = 5'd1;
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                state_d = perm_out;
                key_d   = key_next;
                // Hold the counter on the final round so it never wraps.
                if (rc_q == LAST_RC) begin
                    fsm_d = S_DONE;
                end else begin
                    rc_d = rc_q + 5'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            key_q   <= '0;
            rc_q    <= 5'd1;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
        end
    end

    // ---------------- outputs ----------------
    assign in_ready   = (fsm_q == S_IDLE);
    assign out_valid  = (fsm_q == S_DONE);
    assign busy       = (fsm_q != S_IDLE);
    // Final whitening key add; only the registered state feeds this path.
    assign ciphertext = out_valid ? add_key : 64'h0;

endmodule

// File: tb/tb_present80_enc_core.sv
module tb_present80_enc_core;
    localparam int NR = 31;
    localparam logic [63:0] SBOX_TAB = 64'h21748FE3DA09B65C; // S(i) at nibble i

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] plaintext = '0;
    logic [79:0] key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] ciphertext;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [63:0] exp_q[$];

    present80_enc_core #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference model: straight transcription of the cipher definition.
    function automatic logic [3:0] ref_s(input logic [3:0] x);
        return SBOX_TAB[4*x +: 4];
    endfunction

    function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [79:0] k);
        logic [63:0] s, t;
        for (int r = 1; r <= NR; r++) begin
            s = p ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = ref_s(s[4*n +: 4]);
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
            p = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = ref_s(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return p ^ k[79:16];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", ciphertext);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (ciphertext !== e) begin
                        errors++;
                        $display("FAIL ciphertext: got %h expected %h", ciphertext, e);
                    end
                end
            end else if (!out_valid) begin
                checks++;
                if (ciphertext !== 64'h0) begin
                    errors++;
                    $display("FAIL ct_zero_outside_done: got %h expected 0", ciphertext);
                end
            end
        end
    end

    task automatic send(input logic [63:0] p, input logic [79:0] k, input logic [63:0] e);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        in_valid = 1'b1; plaintext = p; key = k;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        chk("busy_after_accept", {63'b0, busy}, 64'd1);
        chk("in_ready_after_accept", {63'b0, in_ready}, 64'd0);
    endtask

    // One complete transaction: accept, wait for result, optional
    // backpressure, handshake.
    task automatic run(input logic [63:0] p, input logic [79:0] k, input logic [63:0] e,
                       input int bp, input bit pulse);
        int n = 0;
        logic [63:0] ct;
        out_ready = (bp == 0);
        send(p, k, e);
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (out_valid) break;
            if (pulse) begin
                in_valid  = 1'($urandom_range(0, 1));
                plaintext = {$urandom, $urandom};
                key       = {$urandom, $urandom, 16'($urandom)};
            end
        end
        in_valid = 1'b0;
        chk("latency", 64'(n), 64'(NR));
        ct = ciphertext;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_ct_stable", ciphertext, ct);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_hs", {63'b0, in_ready}, 64'd1);
        chk("out_valid_after_hs", {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        int a1;
        logic [63:0] p;
        logic [79:0] k;

        // Reset state
        #23;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_ct", ciphertext, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors
        run(64'h0, 80'h0, 64'h5579C1387B228445, 0, 1'b0);
        run(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 0, 1'b0);
        run({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 0, 1'b0);
        run({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 0, 1'b0);

        // Backpressure for 20 cycles, then accept
        run(64'h0, 80'h0, 64'h5579C1387B228445, 20, 1'b0);

        // in_valid noise during RUN is ignored
        run(64'h0, 80'h0, 64'h5579C1387B228445, 0, 1'b1);

        // Async reset at round 10
        out_ready = 1'b1;
        send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_ct", ciphertext, 64'h0);
        #8 rst_n = 1'b1;
        @(posedge clk); #1;
        run(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 0, 1'b0);
        run({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 0, 1'b0);

        // Back-to-back throughput
        run(64'h0, 80'h0, 64'h5579C1387B228445, 0, 1'b0);
        a1 = acc_cyc;
        run(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 0, 1'b0);
        chk("accept_spacing", 64'(acc_cyc - a1), 64'(NR + 2));

        // Randomized blocks against the reference model
        for (int i = 0; i < 10; i++) begin
            p = {$urandom, $urandom};
            k = {$urandom, $urandom, 16'($urandom)};
            run(p, k, ref_enc(p, k), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
